// File: rtl/uart_byte_tx.sv
// 8N1 UART byte transmitter: one start bit, eight data bits LSB first, one stop bit.
// Accepts a byte on a one-cycle Send_en pulse while idle and reports busy and done.
module uart_byte_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int DIV_9600   = CLK_FREQ / 9600,
    parameter int DIV_19200  = CLK_FREQ / 19200,
    parameter int DIV_38400  = CLK_FREQ / 38400,
    parameter int DIV_57600  = CLK_FREQ / 57600,
    parameter int DIV_115200 = CLK_FREQ / 115200
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] Data_byte,
    input  logic       Send_en,
    input  logic [2:0] baud_set,
    output logic       Rs232_Tx,
    output logic       Tx_Done,
    output logic       uart_state
);

    // The slowest rate sets the counter width; the counter only ever holds DIV-1.
    localparam int CNT_W = $clog2(DIV_9600);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] div_sel;
    logic [CNT_W-1:0] div_last_q;
    logic [CNT_W-1:0] bit_cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       data_q;

    // Unused codes fall back to 9600 baud.
    always_comb begin
        div_sel = CNT_W'(DIV_9600 - 1);
        case (baud_set)
            3'd1:    div_sel = CNT_W'(DIV_19200 - 1);
            3'd2:    div_sel = CNT_W'(DIV_38400 - 1);
            3'd3:    div_sel = CNT_W'(DIV_57600 - 1);
            3'd4:    div_sel = CNT_W'(DIV_115200 - 1);
            default: div_sel = CNT_W'(DIV_9600 - 1);
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            Rs232_Tx   <= 1'b1;
            Tx_Done    <= 1'b0;
            uart_state <= 1'b0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            data_q     <= '0;
            div_last_q <= '0;
        end else begin
            Tx_Done <= 1'b0;
            case (state)
                IDLE: begin
                    Rs232_Tx <= 1'b1;
                    if (Send_en) begin
                        data_q     <= Data_byte;
                        div_last_q <= div_sel;
                        bit_cnt    <= '0;
                        bit_idx    <= '0;
                        Rs232_Tx   <= 1'b0;
                        uart_state <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    // bit_idx names the bit currently on the line: 0 start, 1..8 data, 9 stop.
                    if (bit_cnt == div_last_q) begin
                        bit_cnt <= '0;
                        if (bit_idx == 4'd9) begin
                            bit_idx    <= '0;
                            Rs232_Tx   <= 1'b1;
                            uart_state <= 1'b0;
                            Tx_Done    <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            bit_idx  <= bit_idx + 4'd1;
                            Rs232_Tx <= (bit_idx < 4'd8) ? data_q[bit_idx[2:0]] : 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: a frame-timeline model checked every cycle, a line decoder,
// and directed frames with hand-computed frame lengths and decoded bytes.
module tb_uart_byte_tx;

    // A 5 MHz clock keeps 9600-baud frames short: DIV = 520, 260, 130, 86, 43.
    localparam int CLK_FREQ = 5_000_000;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b1;
    logic [7:0] Data_byte = 8'h00;
    logic       Send_en = 1'b0;
    logic [2:0] baud_set = 3'd0;
    logic       Rs232_Tx;
    logic       Tx_Done;
    logic       uart_state;

    int vectors = 0;
    int miscompares = 0;
    int fail_prints = 0;

    always #5 Clk = ~Clk;

    uart_byte_tx #(.CLK_FREQ(CLK_FREQ)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Data_byte  (Data_byte),
        .Send_en    (Send_en),
        .baud_set   (baud_set),
        .Rs232_Tx   (Rs232_Tx),
        .Tx_Done    (Tx_Done),
        .uart_state (uart_state)
    );

    function automatic int div_of(input logic [2:0] b);
        case (b)
            3'd1:    return CLK_FREQ / 19200;
            3'd2:    return CLK_FREQ / 38400;
            3'd3:    return CLK_FREQ / 57600;
            3'd4:    return CLK_FREQ / 115200;
            default: return CLK_FREQ / 9600;
        endcase
    endfunction

    // Model: m_t counts clocks since the accepting edge; the frame occupies t < 10*DIV.
    bit         m_active = 1'b0;
    int         m_t = 0;
    int         m_div = 1;
    logic [7:0] m_byte = 8'h00;
    bit         busy_pre;
    int         cycle = 0;
    int         accept_cycle = 0;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_active = 1'b0;
            m_t      = 0;
        end else begin
            cycle++;
            busy_pre = m_active && (m_t < 10 * m_div);
            if (!busy_pre && Send_en) begin
                m_active     = 1'b1;
                m_t          = 0;
                m_byte       = Data_byte;
                m_div        = div_of(baud_set);
                accept_cycle = cycle;
            end else if (m_active) begin
                m_t++;
                if (m_t > 10 * m_div) m_active = 1'b0;
            end
        end
    end

    function automatic logic exp_busy();
        return m_active && (m_t < 10 * m_div);
    endfunction

    function automatic logic exp_done();
        return m_active && (m_t == 10 * m_div);
    endfunction

    function automatic logic exp_line();
        int k;
        if (!exp_busy()) return 1'b1;
        k = m_t / m_div;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (fail_prints < 30) begin
                fail_prints++;
                $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
            end
        end
    endtask

    // Per-cycle compare, Tx_Done bookkeeping and a mid-bit line decoder.
    logic [7:0] rx_shift = 8'h00;
    logic [7:0] rx_q[$];
    int         done_cnt = 0;
    int         done_cycle = 0;

    always @(posedge Clk) begin
        #1;
        if (Rst_n) begin
            checkOutput("Rs232_Tx", {31'd0, Rs232_Tx}, {31'd0, exp_line()});
            checkOutput("Tx_Done", {31'd0, Tx_Done}, {31'd0, exp_done()});
            checkOutput("uart_state", {31'd0, uart_state}, {31'd0, exp_busy()});
            if (Tx_Done === 1'b1) begin
                done_cnt++;
                done_cycle = cycle;
            end
            if (exp_busy() && (m_t % m_div == m_div / 2)) begin
                if (m_t / m_div >= 1 && m_t / m_div <= 8) rx_shift[m_t / m_div - 1] = Rs232_Tx;
                else if (m_t / m_div == 9) rx_q.push_back(rx_shift);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input logic [2:0] baud);
        @(negedge Clk);
        Data_byte = b;
        baud_set  = baud;
        Send_en   = 1'b1;
        @(posedge Clk);
        #1 Send_en = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < limit) begin
            @(posedge Clk);
            #2;
            n++;
        end
        checkOutput("done_seen", done_cnt - start, 1);
    endtask

    task automatic frameLen(input int exp);
        checkOutput("frame_len", done_cycle - accept_cycle, exp);
    endtask

    initial begin
        #(1_000_000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] exp_rx[11];
        int d;
        exp_rx = '{8'h55, 8'hA3, 8'hA3, 8'h5A, 8'h5A, 8'h5A, 8'h0F, 8'hFF, 8'h01, 8'h96, 8'h3C};

        #2 Rst_n = 1'b0;
        #1;
        checkOutput("reset_tx", {31'd0, Rs232_Tx}, 1);
        checkOutput("reset_done", {31'd0, Tx_Done}, 0);
        checkOutput("reset_busy", {31'd0, uart_state}, 0);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (5) @(negedge Clk);

        // 0x55 at 115200: start bit one clock after the request, 430-clock frame.
        applyStimulus(8'h55, 3'd4);
        checkOutput("start_tx", {31'd0, Rs232_Tx}, 0);
        checkOutput("start_busy", {31'd0, uart_state}, 1);
        waitDone(1000);
        frameLen(430);

        // 0xA3 at 9600 and via the fallback code 7, then the middle rates.
        applyStimulus(8'hA3, 3'd0);
        waitDone(6000);
        frameLen(5200);
        applyStimulus(8'hA3, 3'd7);
        waitDone(6000);
        frameLen(5200);
        applyStimulus(8'h5A, 3'd1);
        waitDone(3000);
        frameLen(2600);
        applyStimulus(8'h5A, 3'd2);
        waitDone(2000);
        frameLen(1300);
        applyStimulus(8'h5A, 3'd3);
        waitDone(1000);
        frameLen(860);

        // A request during data bit 3 is dropped.
        applyStimulus(8'h0F, 3'd4);
        repeat (4 * 43 + 5) @(posedge Clk);
        applyStimulus(8'hF0, 3'd4);
        waitDone(1000);
        frameLen(430);
        d = done_cnt;
        repeat (600) @(posedge Clk);
        #2;
        checkOutput("no_second_frame", done_cnt - d, 0);
        checkOutput("idle_after_busy", {31'd0, uart_state}, 0);

        // Back-to-back: the next request lands in the Tx_Done cycle.
        applyStimulus(8'hFF, 3'd4);
        waitDone(1000);
        frameLen(430);
        applyStimulus(8'h01, 3'd4);
        checkOutput("b2b_gap", accept_cycle - done_cycle, 1);
        checkOutput("b2b_start_tx", {31'd0, Rs232_Tx}, 0);
        checkOutput("b2b_busy", {31'd0, uart_state}, 1);
        waitDone(1000);
        frameLen(430);

        // Mid-frame baud and data changes must not disturb the frame.
        applyStimulus(8'h96, 3'd4);
        repeat (2 * 43 + 5) @(posedge Clk);
        @(negedge Clk);
        baud_set  = 3'd0;
        Data_byte = 8'h00;
        waitDone(1000);
        frameLen(430);

        // Reset during data bit 4 (line bit 5) aborts without Tx_Done.
        applyStimulus(8'hC3, 3'd4);
        repeat (5 * 43 + 10) @(posedge Clk);
        d = done_cnt;
        #3 Rst_n = 1'b0;
        #1;
        checkOutput("abort_tx", {31'd0, Rs232_Tx}, 1);
        checkOutput("abort_busy", {31'd0, uart_state}, 0);
        checkOutput("abort_done", {31'd0, Tx_Done}, 0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (500) @(posedge Clk);
        #2;
        checkOutput("abort_no_done", done_cnt - d, 0);
        applyStimulus(8'h3C, 3'd4);
        waitDone(1000);
        frameLen(430);

        repeat (20) @(posedge Clk);
        checkOutput("rx_count", rx_q.size(), 11);
        for (int i = 0; i < 11; i++) begin
            if (i < rx_q.size()) checkOutput("rx_byte", {24'd0, rx_q[i]}, {24'd0, exp_rx[i]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- Serialises one byte onto an RS-232 TX line as 8N1: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Sits directly downstream of the key-counter control stage.
- Consumes that stage's Data_byte and its one-cycle Send_en pulse, and drives the board's UART TX pin.
- Reports busy status and a one-cycle completion pulse.

Parameters:
- CLK_FREQ, 50_000_000, Clk frequency in Hz; used to derive bit periods.
- DIV_9600, CLK_FREQ/9600, cycles per bit for baud_set=0 (5208 at 50 MHz).
- DIV_19200, CLK_FREQ/19200, cycles per bit for baud_set=1 (2604).
- DIV_38400, CLK_FREQ/38400, cycles per bit for baud_set=2 (1302).
- DIV_57600, CLK_FREQ/57600, cycles per bit for baud_set=3 (868).
- DIV_115200, CLK_FREQ/115200, cycles per bit for baud_set=4 (434).

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  asynchronous, active-low reset
- Data_byte  in  8  byte to transmit; sampled only on an accepted Send_en
- Send_en  in  1  single-cycle transmit request
- baud_set  in  3  baud select; codes 0-4 per Parameters, codes 5-7 select 9600
- Rs232_Tx  out  1  serial line, idle high
- Tx_Done  out  1  one-cycle pulse marking end of the stop bit
- uart_state  out  1  1 = frame in progress (busy)

Behaviour:
- Reset (async assert, sync release):
  - Rs232_Tx=1, Tx_Done=0, uart_state=0.
  - Bit-period counter, bit index and data/baud latches are cleared.
  - Reset asserted mid-frame aborts the frame immediately: the line returns high, and no Tx_Done is issued.
- Internal state machine, two states:
  - IDLE (uart_state=0)
  - SEND (uart_state=1)
- IDLE:
  - Rs232_Tx=1.
  - Send_en=1 sampled at edge N: Data_byte and the baud divider (from baud_set) are latched into registers.
  - From edge N: uart_state=1 and Rs232_Tx=0 (start bit). Latency is one clock.
- SEND, bit timing:
  - Bit-period counter runs 0..DIV-1.
  - On each wrap the bit index advances and Rs232_Tx updates.
  - Every bit is held exactly DIV cycles.
  - Sequence: start(0), d0, d1 ... d7, stop(1).
  - Rs232_Tx is driven from a register only (glitch-free).
- SEND, end of frame:
  - Falling edge of the start bit to the end of the stop bit = 10*DIV cycles.
  - At edge N+10*DIV: uart_state=0 and Tx_Done=1 for exactly one cycle.
  - Rs232_Tx stays 1 (idle).
- Send_en while uart_state=1: ignored. No queueing, and no corruption of the byte in flight.
- Send_en in the same cycle that Tx_Done is high is accepted: uart_state is 0 in that cycle, giving a back-to-back frame with no idle gap beyond the stop bit.
- Data_byte and baud_set changing mid-frame have no effect; both are latched only at acceptance.
- Counter widths:
  - Bit-period counter is wide enough for the largest DIV: 13 bits at 50 MHz. Derive the width from DIV_9600.
  - Bit index is 4 bits.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. CLK_FREQ=50e6, baud_set=4, Data_byte=8'h55, Send_en pulse:
   - Rs232_Tx falls one clock later.
   - Line reads 0,1,0,1,0,1,0,1,0,1, each held 434 cycles.
   - Tx_Done pulses at start+4340 cycles.
   - uart_state is high for exactly 4340 cycles.
2. baud_set=0, Data_byte=8'hA3:
   - Bit width is 5208 cycles.
   - Decoded byte is 0xA3 (LSB first: 1,1,0,0,0,1,0,1).
   - baud_set=7 gives the same 5208-cycle timing.
3. Busy rejection:
   - Send 8'h0F, then pulse Send_en with Data_byte=8'hF0 at bit 3.
   - Only 0x0F is transmitted, with one Tx_Done and no second frame.
4. Back-to-back:
   - Pulse Send_en with 8'h01 in the Tx_Done cycle of a preceding 8'hFF frame.
   - Start bit of the second frame begins on the very next clock.
   - Decoded bytes are 0xFF then 0x01.
5. Mid-frame changes:
   - Change baud_set 4->0 and Data_byte during bit 2.
   - Frame keeps 434-cycle bits and the original byte.
6. Reset mid-frame:
   - Assert Rst_n=0 during bit 5.
   - Rs232_Tx=1 and uart_state=0 asynchronously, with no Tx_Done.
   - After release, a new Send_en with 8'h3C transmits correctly.
